// File: rtl/buffer_pkg.sv
// Shared sizing helpers and parameter legality check for the wide-to-narrow buffer.
package buffer_pkg;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   // Lane index/count width; never narrower than one bit.
   function automatic int lane_idx_w(input int r);
      return (r < 2) ? 1 : $clog2(r);
   endfunction

   // Level must represent 0..depth inclusive.
   function automatic int level_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit params_legal(input int in_w, input int out_w, input int depth);
      return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2) &&
             (depth >= 2) && is_pow2(depth);
   endfunction

endpackage

// File: rtl/fifo_sc_cnt.sv
// Single-clock FIFO with explicit occupancy count; dout is registered on pop.
module fifo_sc_cnt
   import buffer_pkg::*;
#(
   parameter int W     = 514,
   parameter int DEPTH = 256,
   localparam int CW   = level_w(DEPTH),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          we,
   input  logic          re,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          we_ok;
   logic          re_ok;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   // Full blocks writes even if a pop happens on the same edge: no bypass.
   assign we_ok = we && !full;
   assign re_ok = re && !empty;

   always_ff @(posedge clk) begin
      if (we_ok && !clr)
         mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         dout  <= '0;
      end else if (clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         dout  <= '0;
      end else begin
         if (we_ok)
            wptr <= wptr + AW'(1);
         if (re_ok) begin
            rptr <= rptr + AW'(1);
            dout <= mem[rptr];
         end
         case ({we_ok, re_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/buffer_wide_to_narrow.sv
// Wide-to-narrow width converter: FIFO of wide words, head register serialised LSB lane first.
module buffer_wide_to_narrow
   import buffer_pkg::*;
#(
   parameter int IN_W  = 512,
   parameter int OUT_W = 128,
   parameter int DEPTH = 256,
   localparam int R    = IN_W / OUT_W,
   localparam int LW   = lane_idx_w(R),
   localparam int CW   = level_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [IN_W-1:0]  in_data,
   input  logic [LW-1:0]    in_lanes,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    level
);

   localparam int FW = IN_W + LW;

   if (!params_legal(IN_W, OUT_W, DEPTH)) begin : g_param_check
      $error("buffer_wide_to_narrow: IN_W must be a multiple of OUT_W with ratio >= 2, DEPTH a power of two >= 2");
   end

   logic                      hv;
   logic [LW-1:0]             hidx;
   logic [FW-1:0]             head_word;
   logic [LW-1:0]             hlanes;
   logic [R-1:0][OUT_W-1:0]   lane_arr;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      take;
   logic                      load;

   // The FIFO's registered dout doubles as the head data register.
   fifo_sc_cnt #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .we    (in_valid),
      .re    (load),
      .din   ({in_lanes, in_data}),
      .dout  (head_word),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (level)
   );

   assign hlanes    = head_word[IN_W +: LW];
   assign lane_arr  = head_word[IN_W-1:0];
   assign out_valid = hv;
   assign out_last  = hv && (hidx == hlanes);
   assign out_data  = hv ? lane_arr[hidx] : '0;
   assign take      = hv && out_ready;
   assign load      = !fifo_empty && (!hv || (take && out_last));
   assign in_ready  = !fifo_full;
   assign full      = fifo_full;
   assign empty     = fifo_empty && !hv;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hv   <= 1'b0;
         hidx <= '0;
      end else if (clr) begin
         hv   <= 1'b0;
         hidx <= '0;
      end else if (load) begin
         hv   <= 1'b1;
         hidx <= '0;
      end else if (take && out_last) begin
         hv   <= 1'b0;
         hidx <= '0;
      end else if (take) begin
         hidx <= hidx + LW'(1);
      end
   end

endmodule
